// File: rtl/ccff_load_ctrl_if.sv
// Bitstream word handshake between a word source (master) and ccff_load_ctrl (slave).
interface ccff_load_ctrl_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_load_ctrl.sv
// Loads a CHAIN_LEN-bit ccff chain from WORD_W-bit words, MSB first.
// Define CCFF_LOAD_VERIFY_EN to add the verify input and sticky verify_err output.
module ccff_load_ctrl #(
  parameter int unsigned CHAIN_LEN = 10,
  parameter int unsigned WORD_W    = 8
) (
  input  logic            prog_clk,
  input  logic            prog_reset,
  input  logic            start,
  input  logic            abort,
  ccff_load_ctrl_if.slave cfg,
  output logic            ccff_head,
  input  logic            ccff_tail,
  output logic            shift_en,
  output logic            busy,
  output logic            done
`ifdef CCFF_LOAD_VERIFY_EN
  ,
  input  logic            verify,
  output logic            verify_err
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StFin} state_e;

  localparam int unsigned WcntW = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic [WcntW-1:0]  word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              shift_en_q, shift_en_d;
  logic              head_q, head_d;
  logic              ready;
  logic              bit_last, word_last;

  assign bit_last  = (bit_cnt_q + 16'd1) == 16'(CHAIN_LEN);
  assign word_last = (word_cnt_q + WcntW'(1)) == WcntW'(WORD_W);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sreg_d     = sreg_q;
    ready      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          bit_cnt_d = '0;
        end
      end
      StFetch: begin
        // abort masks ready so a word offered in the same cycle is not consumed
        if (abort) begin
          state_d = StIdle;
        end else begin
          ready = 1'b1;
          if (cfg.cfg_valid) begin
            sreg_d     = cfg.cfg_data;
            word_cnt_d = '0;
            state_d    = StShift;
          end
        end
      end
      StShift: begin
        sreg_d     = sreg_q << 1;
        bit_cnt_d  = bit_cnt_q + 16'd1;
        word_cnt_d = word_cnt_q + WcntW'(1);
        if (abort) begin
          state_d = StIdle;
        end else if (bit_last) begin
          state_d = StFin;
        end else if (word_last) begin
          state_d = StFetch;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // outputs are registered: they follow the state being entered
    shift_en_d = (state_d == StShift);
    head_d     = shift_en_d & sreg_d[WORD_W-1];
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sreg_q     <= '0;
      shift_en_q <= 1'b0;
      head_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sreg_q     <= sreg_d;
      shift_en_q <= shift_en_d;
      head_q     <= head_d;
    end
  end

  assign cfg.cfg_ready = ready;
  assign shift_en      = shift_en_q;
  assign ccff_head     = head_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFin);

`ifdef CCFF_LOAD_VERIFY_EN
  logic verify_q;
  logic verify_err_q;

  // tail replays the previous pass, so it must match head cycle for cycle
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      verify_q     <= 1'b0;
      verify_err_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      verify_q <= verify;
      if (verify) begin
        verify_err_q <= 1'b0;
      end
    end else if (shift_en_q && verify_q && (ccff_tail != head_q)) begin
      verify_err_q <= 1'b1;
    end
  end

  assign verify_err = verify_err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// Scoreboard bench for ccff_load_ctrl: a word-level model queues the expected head bits.
module tb_ccff_load_ctrl;

  localparam int CL = 10;
  localparam int WW = 8;

  logic prog_clk;
  logic prog_reset;
  logic start, abort;
  logic ccff_head, ccff_tail, shift_en, busy, done;
  ccff_load_ctrl_if #(.WORD_W(WW)) cfg_bus ();

  logic s8_start, s8_abort, s8_tail, s8_head, s8_shift_en, s8_busy, s8_done;
  ccff_load_ctrl_if #(.WORD_W(8)) cfg8 ();

`ifdef CCFF_LOAD_VERIFY_EN
  logic verify, verify_err, s8_verify, s8_verify_err;
`endif

  ccff_load_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (start),
    .abort      (abort),
    .cfg        (cfg_bus),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done)
`ifdef CCFF_LOAD_VERIFY_EN
    ,
    .verify     (verify),
    .verify_err (verify_err)
`endif
  );

  ccff_load_ctrl #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (s8_start),
    .abort      (s8_abort),
    .cfg        (cfg8),
    .ccff_head  (s8_head),
    .ccff_tail  (s8_tail),
    .shift_en   (s8_shift_en),
    .busy       (s8_busy),
    .done       (s8_done)
`ifdef CCFF_LOAD_VERIFY_EN
    ,
    .verify     (s8_verify),
    .verify_err (s8_verify_err)
`endif
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: shifts head in on enabled edges, tail is the oldest bit.
  logic [CL-1:0] chain = '0;
  always @(posedge prog_clk) if (shift_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  int comps = 0;
  int errs = 0;
  bit exp_q[$];
  int acc_cnt = 0;
  int done_cnt = 0;
  bit done_prev = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every shifting cycle must present the next queued bit.
  always @(negedge prog_clk) begin
    if (shift_en === 1'b1) begin
      if (exp_q.size() == 0) check("extra_shift", 1, 0);
      else check("head_bit", ccff_head, exp_q.pop_front());
    end else begin
      check("head_idle_zero", ccff_head, 0);
    end
    if (done_prev) check("busy_after_done", busy, 0);
    done_prev = (done === 1'b1);
    if (done === 1'b1) done_cnt++;
    if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) acc_cnt++;
  end

  task automatic check_zero(string tag);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, cfg_bus.cfg_ready, 0);
`ifdef CCFF_LOAD_VERIFY_EN
    check({tag, "_verify_err"}, verify_err, 0);
`endif
  endtask

  // mode 0 normal, 1 abort at SHIFT cycle stop_at, 2 reset at SHIFT cycle stop_at,
  // 3 abort together with cfg_valid in the FETCH of the second word.
  task automatic do_pass(input logic [7:0] w0, input logic [7:0] w1, input bit vfy,
                         input int mode, input int stop_at, input int fixed_stall);
    logic [7:0] words [2];
    int nbits, exp_words, exp_done, acc0, done0, widx, shifts, stall, cyc;
    bit fin, abort_next;
    words[0] = w0;
    words[1] = w1;
    case (mode)
      1, 2:    nbits = stop_at;
      3:       nbits = WW;
      default: nbits = CL;
    endcase
    for (int i = 0; i < nbits; i++) exp_q.push_back(words[i / WW][WW - 1 - (i % WW)]);
    exp_words = (nbits + WW - 1) / WW;
    exp_done  = (mode == 0) ? 1 : 0;
    acc0  = acc_cnt;
    done0 = done_cnt;
`ifdef CCFF_LOAD_VERIFY_EN
    verify = vfy;
`endif
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
`ifdef CCFF_LOAD_VERIFY_EN
    verify = 1'b0;
`endif
    widx = 0; shifts = 0; cyc = 0; fin = 1'b0; abort_next = 1'b0;
    stall = (fixed_stall >= 0) ? 0 : $urandom_range(0, 4);
    while (!fin) begin
      abort = abort_next;
      abort_next = 1'b0;
      if (widx < 2 && (stall == 0 || abort)) begin
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_data  = words[widx];
      end else begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_data  = 8'($urandom);
      end
      @(negedge prog_clk); #1;
      if (!busy) begin
        fin = 1'b1;
      end else begin
        if (shift_en) shifts++;
        if (abort && mode == 3) check("ready_on_abort", cfg_bus.cfg_ready, 0);
        if (cfg_bus.cfg_valid && cfg_bus.cfg_ready) begin
          widx++;
          stall = (fixed_stall >= 0) ? fixed_stall : $urandom_range(0, 4);
        end else if (stall > 0 && cfg_bus.cfg_ready) begin
          stall--;
        end
        if (shift_en && shifts == stop_at && mode == 1) abort = 1'b1;
        if (shift_en && shifts == WW && mode == 3) abort_next = 1'b1;
        if (shift_en && shifts == stop_at && mode == 2) begin
          prog_reset = 1'b1;
          #1;
          check_zero("async_reset");
          exp_q.delete();
        end else if ($urandom_range(0, 7) == 0) begin
          start = 1'b1;
        end
      end
      cyc++;
      if (cyc > 300) begin
        check("pass_timeout", 1, 0);
        fin = 1'b1;
      end
      @(posedge prog_clk); #1;
      start = 1'b0;
      prog_reset = 1'b0;
    end
    abort = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    if (mode != 2) begin
      check("bits_left", exp_q.size(), 0);
      check("shift_cycles", shifts, nbits);
      check("words_taken", acc_cnt - acc0, exp_words);
    end
    check("done_pulses", done_cnt - done0, exp_done);
  endtask

  initial begin
    logic [7:0] bits8;
    int n_sh, n_acc, n_done;
    prog_reset = 1'b1;
    start = 1'b0; abort = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_data = '0;
    s8_start = 1'b0; s8_abort = 1'b0; s8_tail = 1'b0;
    cfg8.cfg_valid = 1'b0; cfg8.cfg_data = '0;
`ifdef CCFF_LOAD_VERIFY_EN
    verify = 1'b0; s8_verify = 1'b0;
`endif
    #1;
    check_zero("reset");
    repeat (2) @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;
    @(posedge prog_clk); #1;

    do_pass(8'hA5, 8'hC0, 1'b0, 0, 0, 0);
    do_pass(8'h3C, 8'h80, 1'b0, 0, 0, 5);
    do_pass(8'h5A, 8'h40, 1'b0, 1, 4, 0);
    do_pass(8'hF0, 8'hFF, 1'b0, 0, 0, -1);
    do_pass(8'h96, 8'hC0, 1'b0, 2, 5, 0);
    do_pass(8'h69, 8'h40, 1'b0, 0, 0, 0);
    do_pass(8'h81, 8'hC0, 1'b0, 3, 0, 0);
    do_pass(8'h7E, 8'h00, 1'b0, 1, CL, 0);

`ifdef CCFF_LOAD_VERIFY_EN
    do_pass(8'hA5, 8'hC0, 1'b0, 0, 0, 0);
    do_pass(8'hA5, 8'hC0, 1'b1, 0, 0, -1);
    check("verify_match", verify_err, 0);
    do_pass(8'hA4, 8'hC0, 1'b1, 0, 0, -1);
    check("verify_mismatch", verify_err, 1);
    do_pass(8'hA5, 8'hC0, 1'b0, 0, 0, 0);
    check("verify_sticky", verify_err, 1);
    do_pass(8'hA5, 8'hC0, 1'b1, 0, 0, 0);
    check("verify_cleared", verify_err, 0);
`endif

    for (int p = 0; p < 24; p++) begin
      do_pass(8'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3),
              $urandom_range(1, CL), -1);
    end

    // Full-word chain with a start issued while busy and cfg_valid held high.
    n_sh = 0; n_acc = 0; n_done = 0; bits8 = '0;
    cfg8.cfg_valid = 1'b1;
    cfg8.cfg_data  = 8'h3C;
    s8_start = 1'b1;
    @(posedge prog_clk); #1;
    s8_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) s8_start = 1'b1;
      @(negedge prog_clk); #1;
      if (s8_shift_en) begin
        bits8 = {bits8[6:0], s8_head};
        n_sh++;
      end
      if (cfg8.cfg_valid && cfg8.cfg_ready) n_acc++;
      if (s8_done) n_done++;
      @(posedge prog_clk); #1;
      s8_start = 1'b0;
    end
    check("c8_words", n_acc, 1);
    check("c8_shifts", n_sh, 8);
    check("c8_bits", bits8, 8'h3C);
    check("c8_done", n_done, 1);
    check("c8_idle", s8_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", comps, errs);
    $finish;
  end

endmodule
